// File: rtl/alu_arbiter_if.sv
// Signal bundle tying alu_arbiter to its two requesters, the shared ALU and the result consumer.
interface alu_arbiter_if #(
   parameter int DATA_W   = 8,
   parameter int FUNSEL_W = 4,
   parameter int FLAG_W   = 4
);
   logic                r0_req;
   logic [DATA_W-1:0]   r0_a;
   logic [DATA_W-1:0]   r0_b;
   logic [FUNSEL_W-1:0] r0_funsel;
   logic                r0_ack;

   logic                r1_req;
   logic [DATA_W-1:0]   r1_a;
   logic [DATA_W-1:0]   r1_b;
   logic [FUNSEL_W-1:0] r1_funsel;
   logic                r1_ack;

   logic [DATA_W-1:0]   alu_a;
   logic [DATA_W-1:0]   alu_b;
   logic [FUNSEL_W-1:0] alu_funsel;
   logic [DATA_W-1:0]   alu_out;
   logic [FLAG_W-1:0]   alu_zcno;

   logic [DATA_W-1:0]   res_out;
   logic [FLAG_W-1:0]   res_zcno;
   logic                res_id;
   logic                res_valid;
   logic                res_ready;
   logic                busy;

   modport slave (
      input  r0_req, r0_a, r0_b, r0_funsel,
             r1_req, r1_a, r1_b, r1_funsel,
             alu_out, alu_zcno, res_ready,
      output r0_ack, r1_ack, alu_a, alu_b, alu_funsel,
             res_out, res_zcno, res_id, res_valid, busy
   );

   modport master (
      output r0_req, r0_a, r0_b, r0_funsel,
             r1_req, r1_a, r1_b, r1_funsel,
             alu_out, alu_zcno, res_ready,
      input  r0_ack, r1_ack, alu_a, alu_b, alu_funsel,
             res_out, res_zcno, res_id, res_valid, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters: Ack 1 cycle after Req, Res_Valid FLAG_LAT+2 cycles after Req.
// Result is held in RESULT until res_ready; requests arriving outside IDLE wait (Req stays high until Ack).
module alu_arbiter #(
   parameter int DATA_W   = 8,
   parameter int FUNSEL_W = 4,
   parameter int FLAG_W   = 4,
   parameter int FLAG_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   alu_arbiter_if.slave bus
);
   localparam int              CNT_W    = (FLAG_LAT > 1) ? $clog2(FLAG_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLAG_LAT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESULT  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic                grant;
   logic                winner;
   logic                ack0;
   logic                ack1;

   logic                last;
   logic [DATA_W-1:0]   alu_a;
   logic [DATA_W-1:0]   alu_b;
   logic [FUNSEL_W-1:0] alu_funsel;
   logic [DATA_W-1:0]   res_out;
   logic [FLAG_W-1:0]   res_zcno;
   logic                res_id;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      grant     = 1'b0;
      ack0      = 1'b0;
      ack1      = 1'b0;
      // on contention the requester that did not win last time goes first
      winner    = (bus.r0_req && bus.r1_req) ? ~last : bus.r1_req;
      case (state)
         IDLE: begin
            if (bus.r0_req || bus.r1_req) begin
               grant     = 1'b1;
               cnt_nxt   = '0;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            ack0 = (cnt == '0) && !res_id;
            ack1 = (cnt == '0) &&  res_id;
            if (cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               state_nxt = CAPTURE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         CAPTURE: state_nxt = RESULT;
         RESULT: begin
            if (bus.res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last       <= 1'b1;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_funsel <= '0;
         res_out    <= '0;
         res_zcno   <= '0;
         res_id     <= 1'b0;
      end else begin
         if (grant) begin
            alu_a      <= winner ? bus.r1_a      : bus.r0_a;
            alu_b      <= winner ? bus.r1_b      : bus.r0_b;
            alu_funsel <= winner ? bus.r1_funsel : bus.r0_funsel;
            last       <= winner;
            res_id     <= winner;
         end
         if (state == CAPTURE) begin
            res_out  <= bus.alu_out;
            res_zcno <= bus.alu_zcno;
         end
      end
   end

   assign bus.r0_ack     = ack0;
   assign bus.r1_ack     = ack1;
   assign bus.alu_a      = alu_a;
   assign bus.alu_b      = alu_b;
   assign bus.alu_funsel = alu_funsel;
   assign bus.res_out    = res_out;
   assign bus.res_zcno   = res_zcno;
   assign bus.res_id     = res_id;
   assign bus.res_valid  = (state == RESULT);
   assign bus.busy       = (state != IDLE);
endmodule
